// File: rtl/game_pkg.sv
// Shared game encodings: status codes, move directions and move arbiter states.
package game_pkg;

  localparam logic [1:0] CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] GAMING       = 2'b01;
  localparam logic [1:0] GAME_INITIAL = 2'b10;
  localparam logic [1:0] WINNED       = 2'b11;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_COOL  = 2'b11
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on a tie the source that did not win last time is chosen.
module rr_arb2 (
  input  logic       clk_d,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic last_q;
  logic last_d;

  assign gnt_vld_o = |req_i;
  assign gnt_idx_o = (&req_i) ? ~last_q : req_i[1];
  assign last_d    = take_i ? gnt_idx_o : last_q;

  // Reset to source 1 so the buttons win the very first tie.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/move_arbiter.sv
// Sequences button/keyboard moves into the board, one outstanding at a time, and pulses active per legal move.
// Optional MOVE_TIMEOUT_EN: abort a move whose board_done never arrives and raise sticky timeout_err.
module move_arbiter
  import game_pkg::*;
#(
  parameter int COOLDOWN_CYC = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic       clk_d,
  input  logic       rst,
  input  logic [1:0] game_status,
  input  logic       btn_req,
  input  logic [1:0] btn_dir,
  input  logic       kbd_req,
  input  logic [1:0] kbd_dir,
  output logic       btn_ack,
  output logic       kbd_ack,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  input  logic       board_done,
  input  logic       board_moved,
  output logic       active,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [4:0] COOL_LEN = 5'(COOLDOWN_CYC);

  arb_state_e state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic       btn_ack_q, btn_ack_d;
  logic       kbd_ack_q, kbd_ack_d;
  logic       active_q, active_d;
  logic [3:0] cool_cnt_q, cool_cnt_d;
  logic       play_ok;
  logic       take;
  logic       gnt_vld;
  logic       gnt_idx;

  assign play_ok = (game_status == GAMING) || (game_status == GAME_INITIAL);

  rr_arb2 u_rr (
    .clk_d     (clk_d),
    .rst       (rst),
    .req_i     ({kbd_req, btn_req}),
    .take_i    (take),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

`ifdef MOVE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;
  assign timeout_err = tmo_err_q;
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYC != 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= 2'b00;
      btn_ack_q  <= 1'b0;
      kbd_ack_q  <= 1'b0;
      active_q   <= 1'b0;
      cool_cnt_q <= 4'd0;
`ifdef MOVE_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      btn_ack_q  <= btn_ack_d;
      kbd_ack_q  <= kbd_ack_d;
      active_q   <= active_d;
      cool_cnt_q <= cool_cnt_d;
`ifdef MOVE_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_err_q  <= tmo_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    btn_ack_d  = 1'b0;
    kbd_ack_d  = 1'b0;
    active_d   = 1'b0;
    cool_cnt_d = cool_cnt_q;
    take       = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_err_d  = tmo_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (play_ok && gnt_vld) begin
          take      = 1'b1;
          state_d   = ST_ISSUE;
          dir_d     = gnt_idx ? kbd_dir : btn_dir;
          btn_ack_d = ~gnt_idx;
          kbd_ack_d = gnt_idx;
        end
      end
      ST_ISSUE: begin
`ifdef MOVE_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        // A completed handshake is honoured even if play_ok drops in the same cycle.
        if (move_ready)    state_d = ST_WAIT;
        else if (!play_ok) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (game_status == CHOSE_BOARD) begin
          state_d = ST_IDLE;
        end else if (board_done) begin
          active_d   = board_moved;
          state_d    = ST_COOL;
          cool_cnt_d = 4'd0;
        end
`ifdef MOVE_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          tmo_err_d  = 1'b1;
          state_d    = ST_COOL;
          cool_cnt_d = 4'd0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_COOL: begin
        // Zero cooldown still spends one cycle here.
        if (({1'b0, cool_cnt_q} + 5'd1) >= COOL_LEN) state_d = ST_IDLE;
        else cool_cnt_d = cool_cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MOVE_TIMEOUT_EN
    if (game_status == CHOSE_BOARD) tmo_err_d = 1'b0;
`endif
  end

  assign btn_ack    = btn_ack_q;
  assign kbd_ack    = kbd_ack_q;
  assign move_valid = (state_q == ST_ISSUE);
  assign move_dir   = dir_q;
  assign active     = active_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
